// File: rtl/sdram_responder.sv
// Behavioural SDR SDRAM responder (MT48LC16M16 command subset) backed by a folded
// on-chip array; decodes commands, tracks open rows, returns CL-delayed read data.
module sdram_responder #(
  parameter int ROW_BITS    = 5,
  parameter int COL_BITS    = 5,
  parameter int T_RCD       = 2,
  parameter int REFRESH_MAX = 1600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic [1:0]  SDRAM_BA,
  input  logic [12:0] SDRAM_A,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        mode_loaded,
  output logic        err_proto,
  output logic        err_timing,
  output logic        err_refresh
);

  localparam int AW    = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(T_RCD + 2);
  localparam int RW    = $clog2(REFRESH_MAX + 2);
  localparam logic [TW-1:0] T_SAT = TW'(T_RCD);
  localparam logic [RW-1:0] R_MAX = RW'(REFRESH_MAX);
  localparam logic [RW-1:0] R_SAT = RW'(REFRESH_MAX + 1);

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  logic [15:0] mem [DEPTH];

  logic [3:0]                bank_open_q, bank_open_d;
  logic [3:0][ROW_BITS-1:0]  row_q, row_d;
  logic [3:0][TW-1:0]        rcd_q, rcd_d;
  logic                      cl3_q, cl3_d;
  logic                      mode_loaded_q, mode_loaded_d;
  logic                      err_proto_q, err_proto_d;
  logic                      err_timing_q, err_timing_d;
  logic                      err_refresh_q, err_refresh_d;
  logic [RW-1:0]             refr_cnt_q, refr_cnt_d;
  logic [1:0]                p_vld_q, p_vld_d;
  logic [1:0][15:0]          p_dat_q, p_dat_d;
  logic                      dq_oe_q, dq_oe_d;
  logic [15:0]               dq_out_q, dq_out_d;

  cmd_e                cmd;
  logic                sel_open;
  logic [ROW_BITS-1:0] sel_row;
  logic [AW-1:0]       mem_idx;
  logic [15:0]         rd_word;
  logic                mem_we;
  logic [1:0]          mem_be;
  logic                rd_load;
  logic                unused_a;

  assign unused_a = ^SDRAM_A;

  always_comb begin
    cmd      = SDRAM_nCS ? CMD_NOP : cmd_e'({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE});
    sel_open = bank_open_q[SDRAM_BA];
    sel_row  = row_q[SDRAM_BA];
    mem_idx  = {SDRAM_BA, sel_row, SDRAM_A[COL_BITS-1:0]};
    rd_word  = mem[mem_idx] & {{8{~SDRAM_DQMH}}, {8{~SDRAM_DQML}}};

    bank_open_d   = bank_open_q;
    row_d         = row_q;
    rcd_d         = rcd_q;
    cl3_d         = cl3_q;
    mode_loaded_d = mode_loaded_q;
    err_proto_d   = err_proto_q;
    err_timing_d  = err_timing_q;
    mem_we        = 1'b0;
    mem_be        = 2'b00;
    rd_load       = 1'b0;

    for (int b = 0; b < 4; b++)
      if (rcd_q[b] != T_SAT) rcd_d[b] = rcd_q[b] + 1'b1;

    case (cmd)
      CMD_LMR: begin
        // CL field must be 2 or 3 (A[6:5]==01) and burst length must be 1
        if (|bank_open_q || SDRAM_A[6:5] != 2'b01 || SDRAM_A[2:0] != 3'b000) begin
          err_proto_d = 1'b1;
        end else begin
          cl3_d         = SDRAM_A[4];
          mode_loaded_d = 1'b1;
        end
      end
      CMD_REF: if (|bank_open_q) err_proto_d = 1'b1;
      CMD_PRE: begin
        if (SDRAM_A[10]) bank_open_d = '0;
        else             bank_open_d[SDRAM_BA] = 1'b0;
      end
      CMD_ACT: begin
        if (!mode_loaded_q || sel_open) begin
          err_proto_d = 1'b1;
        end else begin
          bank_open_d[SDRAM_BA] = 1'b1;
          row_d[SDRAM_BA]       = SDRAM_A[ROW_BITS-1:0];
          rcd_d[SDRAM_BA]       = TW'(1);
        end
      end
      CMD_RD, CMD_WR: begin
        if (!mode_loaded_q || !sel_open) begin
          err_proto_d = 1'b1;
        end else begin
          if (rcd_q[SDRAM_BA] < T_SAT) err_timing_d = 1'b1;
          if (SDRAM_A[10]) bank_open_d[SDRAM_BA] = 1'b0;
          if (cmd == CMD_WR) begin
            mem_we = 1'b1;
            mem_be = {~SDRAM_DQMH, ~SDRAM_DQML};
            // controller is driving DQ while we are returning read data
            if (dq_oe_q) err_proto_d = 1'b1;
          end else begin
            rd_load = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (cmd == CMD_REF)                           refr_cnt_d = '0;
    else if (mode_loaded_q && refr_cnt_q != R_SAT) refr_cnt_d = refr_cnt_q + 1'b1;
    else                                           refr_cnt_d = refr_cnt_q;
    err_refresh_d = err_refresh_q | (refr_cnt_d > R_MAX);

    // stage 1 only used for CL=3; stage 0 feeds the output register
    p_vld_d[1] = rd_load & cl3_q;
    p_dat_d[1] = rd_word;
    p_vld_d[0] = (rd_load & ~cl3_q) | p_vld_q[1];
    p_dat_d[0] = (rd_load & ~cl3_q) ? rd_word : p_dat_q[1];
    dq_oe_d    = p_vld_q[0];
    dq_out_d   = p_vld_q[0] ? p_dat_q[0] : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      if (mem_be[0]) mem[mem_idx][7:0]  <= dq_in[7:0];
      if (mem_be[1]) mem[mem_idx][15:8] <= dq_in[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank_open_q   <= '0;
      row_q         <= '0;
      rcd_q         <= '0;
      cl3_q         <= 1'b0;
      mode_loaded_q <= 1'b0;
      err_proto_q   <= 1'b0;
      err_timing_q  <= 1'b0;
      err_refresh_q <= 1'b0;
      refr_cnt_q    <= '0;
      p_vld_q       <= '0;
      p_dat_q       <= '0;
      dq_oe_q       <= 1'b0;
      dq_out_q      <= '0;
    end else begin
      bank_open_q   <= bank_open_d;
      row_q         <= row_d;
      rcd_q         <= rcd_d;
      cl3_q         <= cl3_d;
      mode_loaded_q <= mode_loaded_d;
      err_proto_q   <= err_proto_d;
      err_timing_q  <= err_timing_d;
      err_refresh_q <= err_refresh_d;
      refr_cnt_q    <= refr_cnt_d;
      p_vld_q       <= p_vld_d;
      p_dat_q       <= p_dat_d;
      dq_oe_q       <= dq_oe_d;
      dq_out_q      <= dq_out_d;
    end
  end

  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign mode_loaded = mode_loaded_q;
  assign err_proto   = err_proto_q;
  assign err_timing  = err_timing_q;
  assign err_refresh = err_refresh_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a vector table for the main command flow
// plus hand-written sequences for mode, timing, refresh and reset corners.
module tb_sdram_responder;

  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                         C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  logic        clk, reset_n;
  logic        nCS, nRAS, nCAS, nWE, DQML, DQMH;
  logic [1:0]  BA;
  logic [12:0] A;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, mode_loaded, err_proto, err_timing, err_refresh;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  sdram_responder dut (
    .clk(clk), .reset_n(reset_n),
    .SDRAM_nCS(nCS), .SDRAM_nRAS(nRAS), .SDRAM_nCAS(nCAS), .SDRAM_nWE(nWE),
    .SDRAM_BA(BA), .SDRAM_A(A), .SDRAM_DQML(DQML), .SDRAM_DQMH(DQMH),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .mode_loaded(mode_loaded),
    .err_proto(err_proto), .err_timing(err_timing), .err_refresh(err_refresh)
  );

  assign flags = {mode_loaded, err_proto, err_timing, err_refresh};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [1:0]  dqm;   // {DQMH, DQML}
    logic [15:0] din;
    logic        oe;
    logic [15:0] dq;
    logic [3:0]  fl;    // {mode_loaded, err_proto, err_timing, err_refresh}
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic [2:0] c, logic [1:0] ba, logic [12:0] a, logic [1:0] dqm,
                             logic [15:0] din, logic oe, logic [15:0] dq, logic [3:0] fl);
    vec_t r;
    r.cmd = c; r.ba = ba; r.a = a; r.dqm = dqm; r.din = din; r.oe = oe; r.dq = dq; r.fl = fl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive one command, let it be sampled, return 1 time unit after the edge
  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] din);
    nCS = 1'b0; {nRAS, nCAS, nWE} = c; BA = ba; A = a; {DQMH, DQML} = dqm; dq_in = din;
    @(posedge clk); #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    nop(2);
    reset_n = 1'b1;
  endtask

  initial begin
    nCS = 1'b1; {nRAS, nCAS, nWE} = 3'b111; BA = '0; A = '0; {DQMH, DQML} = 2'b00; dq_in = '0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    chk("rst_oe", dq_oe, 1'b0);
    chk("rst_dq", dq_out, 16'h0000);
    chk("rst_flags", flags, 4'b0000);

    // main flow: CL=2 write/read, byte masks, back-to-back reads, CL=3, auto-precharge
    tv.push_back(v(C_LMR, 0, 13'h220, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_ACT, 1, 13'h005, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_WR,  1, 13'h003, 2'b00, 16'hBEEF, 0, 16'h0,    4'b1000));
    tv.push_back(v(C_RD,  1, 13'h003, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    1, 16'hBEEF, 4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_WR,  1, 13'h003, 2'b10, 16'h1234, 0, 16'h0,    4'b1000));
    tv.push_back(v(C_RD,  1, 13'h003, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    1, 16'hBE34, 4'b1000));
    tv.push_back(v(C_RD,  1, 13'h003, 2'b01, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    1, 16'hBE00, 4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_WR,  1, 13'h004, 2'b00, 16'h5A5A, 0, 16'h0,    4'b1000));
    tv.push_back(v(C_RD,  1, 13'h003, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_RD,  1, 13'h004, 2'b00, 16'h0,    1, 16'hBE34, 4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    1, 16'h5A5A, 4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_PRE, 0, 13'h400, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_LMR, 0, 13'h230, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_ACT, 1, 13'h005, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_RD,  1, 13'h003, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    1, 16'hBE34, 4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_RD,  1, 13'h404, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    1, 16'h5A5A, 4'b1000));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1000));
    tv.push_back(v(C_RD,  1, 13'h003, 2'b00, 16'h0,    0, 16'h0,    4'b1100));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1100));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1100));
    tv.push_back(v(C_NOP, 0, 13'h000, 2'b00, 16'h0,    0, 16'h0,    4'b1100));

    for (int i = 0; i < tv.size(); i++) begin
      issue(tv[i].cmd, tv[i].ba, tv[i].a, tv[i].dqm, tv[i].din);
      chk($sformatf("vec%0d_oe", i), dq_oe, tv[i].oe);
      if (tv[i].oe) chk($sformatf("vec%0d_dq", i), dq_out, tv[i].dq);
      chk($sformatf("vec%0d_flags", i), flags, tv[i].fl);
    end

    // bad burst length rejected, CL=3 retained
    do_reset();
    issue(C_LMR, 0, 13'h230, 2'b00, 16'h0);
    issue(C_LMR, 0, 13'h231, 2'b00, 16'h0);
    chk("bl_bad_proto", err_proto, 1'b1);
    chk("bl_bad_ml", mode_loaded, 1'b1);
    issue(C_ACT, 0, 13'h002, 2'b00, 16'h0);
    nop(1);
    issue(C_WR, 0, 13'h006, 2'b00, 16'h1357);
    issue(C_RD, 0, 13'h006, 2'b00, 16'h0);
    nop(1);
    chk("cl3_k1_oe", dq_oe, 1'b0);
    nop(1);
    chk("cl3_k2_oe", dq_oe, 1'b1);
    chk("cl3_k2_dq", dq_out, 16'h1357);
    nop(1);
    chk("cl3_k3_oe", dq_oe, 1'b0);

    // tRCD: exactly T_RCD is legal, one cycle is a violation but still executes
    do_reset();
    issue(C_LMR, 0, 13'h220, 2'b00, 16'h0);
    issue(C_ACT, 2, 13'h007, 2'b00, 16'h0);
    nop(1);
    issue(C_WR, 2, 13'h001, 2'b00, 16'hC0DE);
    chk("rcd_ok_timing", err_timing, 1'b0);
    issue(C_PRE, 2, 13'h000, 2'b00, 16'h0);
    issue(C_ACT, 2, 13'h007, 2'b00, 16'h0);
    issue(C_RD, 2, 13'h001, 2'b00, 16'h0);
    chk("rcd_bad_timing", err_timing, 1'b1);
    chk("rcd_bad_proto", err_proto, 1'b0);
    nop(1);
    chk("rcd_bad_oe", dq_oe, 1'b1);
    chk("rcd_bad_dq", dq_out, 16'hC0DE);

    // refresh interval, then AUTO_REFRESH with a bank open
    do_reset();
    issue(C_LMR, 0, 13'h220, 2'b00, 16'h0);
    issue(C_REF, 0, 13'h000, 2'b00, 16'h0);
    nop(1599);
    chk("refr_early", err_refresh, 1'b0);
    nop(4);
    chk("refr_late", err_refresh, 1'b1);
    chk("refr_proto0", err_proto, 1'b0);
    issue(C_ACT, 0, 13'h000, 2'b00, 16'h0);
    issue(C_REF, 0, 13'h000, 2'b00, 16'h0);
    chk("refr_open_proto", err_proto, 1'b1);

    // reset while a read is in flight; array contents survive
    do_reset();
    issue(C_LMR, 0, 13'h220, 2'b00, 16'h0);
    issue(C_ACT, 3, 13'h009, 2'b00, 16'h0);
    nop(1);
    issue(C_WR, 3, 13'h007, 2'b00, 16'h7777);
    issue(C_RD, 3, 13'h007, 2'b00, 16'h0);
    reset_n = 1'b0;
    nop(1);
    chk("rst_rd_oe", dq_oe, 1'b0);
    chk("rst_rd_flags", flags, 4'b0000);
    reset_n = 1'b1;
    nop(1);
    chk("rst_rd_oe2", dq_oe, 1'b0);
    issue(C_LMR, 0, 13'h220, 2'b00, 16'h0);
    issue(C_RD, 3, 13'h007, 2'b00, 16'h0);
    chk("rst_closed_proto", err_proto, 1'b1);
    nop(1);
    chk("rst_closed_oe", dq_oe, 1'b0);
    issue(C_ACT, 3, 13'h009, 2'b00, 16'h0);
    nop(1);
    issue(C_RD, 3, 13'h007, 2'b00, 16'h0);
    nop(1);
    chk("rst_keep_oe", dq_oe, 1'b1);
    chk("rst_keep_dq", dq_out, 16'h7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
